dds_output_reg: RTL and testbench
=================================

// Module: dds_output_reg
// PURPOSE
//  Consumer end of the phase-accumulator -> ROM -> output-register path.
//  Tracks SIGN_START_CALC/SIGN_STOP_CALC from any phase accumulator (LFM/PSK/...) and captures each ROM sample.
//  Packs LANES consecutive samples into one DAC word and buffers words in a FIFO for the DAC interface.
//  Asserts OUT_REG_READY, which gates the accumulators' next burst.
// PARAMETERS
//  DATA_W      12  ROM sample width
//  LANES       4   samples per DAC word (power of 2)
//  FIFO_DEPTH  16  DAC words buffered (power of 2)
//  ROM_LAT     1   ROM read latency in CLK cycles (>=1)
//  PAD_VALUE   0   sample value used to pad the final partial word
// PORTS
//  CLK              in   1              system clock, all logic on posedge
//  RESET            in   1              asynchronous, active-high reset
//  SIGN_START_CALC  in   1              one-cycle pulse; addresses valid from the next cycle
//  SIGN_STOP_CALC   in   1              high in the cycle of the last address of the burst
//  ROM_DATA         in   DATA_W         ROM output, valid ROM_LAT cycles after its address
//  OUT_REG_READY    out  1              ready to accept a new burst
//  DAC_DATA         out  LANES*DATA_W   packed word; lane 0 (LSBs) = earliest sample
//  DAC_VALID        out  1              DAC_DATA valid (FIFO not empty)
//  DAC_READY        in   1              DAC accepts word when DAC_VALID&&DAC_READY
//  OVERFLOW         out  1              sticky: a word was lost because FIFO was full
//  SAMPLE_COUNT     out  32             samples captured in current/last burst
//  BURST_DONE       out  1              one-cycle pulse when burst fully drained
// BEHAVIOUR
//  Reset (async): state IDLE, FIFO empty, lane index 0. Outputs: OUT_REG_READY=1, DAC_VALID=0,
//   DAC_DATA=0, OVERFLOW=0, SAMPLE_COUNT=0, BURST_DONE=0. Delay line cleared.
//  FSM: IDLE -> CAPTURE on SIGN_START_CALC=1 (clears SAMPLE_COUNT; OVERFLOW stays sticky until RESET).
//   CAPTURE: addr_vld=1 each cycle; on cycle with SIGN_STOP_CALC=1 (incl. first cycle) -> DRAIN.
//   DRAIN: ROM_LAT cycles, last samples arrive -> FLUSH.
//   FLUSH: if lane index!=0, fill remaining lanes with PAD_VALUE, push word (1 cycle) -> WAIT.
//   WAIT: when FIFO empty -> IDLE, BURST_DONE=1 for that one cycle.
//  SIGN_START_CALC outside IDLE is ignored. SIGN_STOP_CALC outside CAPTURE is ignored.
//  Capture: addr_vld is delayed ROM_LAT cycles; when the delayed flag=1, ROM_DATA goes into
//   lane[lane index], SAMPLE_COUNT++, lane index++ (mod LANES); when the last lane fills, push word.
//  SAMPLE_COUNT excludes pad samples; saturates at 2^32-1.
//  FIFO: push and pop in the same cycle are both allowed when full. Push while full and no pop:
//   the word is dropped, OVERFLOW<=1. The accumulator is never stalled.
//  DAC side: DAC_DATA = FIFO head (first-word fall-through). DAC_VALID = !empty. Pop on VALID&&READY.
//   Holding DAC_READY low does not affect capture.
//  OUT_REG_READY = (state==IDLE) && FIFO empty, registered. Latency START->first word push = ROM_LAT+LANES cycles.
//  Reset mid-burst: everything aborts immediately to reset values. FIFO contents are discarded.
// STRUCTURE
//  Shared package dds_pkg: state enum {IDLE,CAPTURE,DRAIN,FLUSH,WAIT}, DATA_W default,
//   common signal-type codes.
//  Sub-module sync_fifo (width LANES*DATA_W, depth FIFO_DEPTH, full/empty, FWFT).
//  Top holds FSM, ROM_LAT delay line, lane packer, counters.
// TESTING
//  1. Burst of 8 samples (ROM_DATA=1..8), LANES=4, DAC_READY=1 -> two words 0x004_003_002_001, 0x008_007_006_005;
//     SAMPLE_COUNT=8; BURST_DONE one cycle after last pop; OUT_REG_READY back to 1.
//  2. Burst of 6 samples -> second word lanes 2,3 = PAD_VALUE; SAMPLE_COUNT=6.
//  3. Single-sample burst (STOP coincident with first address) -> one word {0,0,0,data}; FSM returns to IDLE.
//  4. DAC_READY=0 for a 100-sample burst, depth 16 -> 16 words held, OVERFLOW=1, capture continues;
//     then DAC_READY=1 -> exactly 16 words popped, in order.
//  5. RESET asserted mid-CAPTURE -> outputs immediately at reset values. A second SIGN_START_CALC during
//     CAPTURE is ignored (word count unchanged).
//  6. ROM_LAT=3 -> first sample captured 3 cycles after first address; no sample lost or duplicated at the burst end.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared DDS datapath definitions: output-register FSM states, default widths,
// waveform-type codes and a saturating counter helper.
package dds_pkg;

    localparam int unsigned DDS_DATA_W = 12;
    localparam int unsigned DDS_CNT_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        FLUSH,
        WAIT
    } dds_state_e;

    // Waveform kinds produced by the phase accumulators that feed the output register.
    typedef enum logic [1:0] {
        SIG_CW,
        SIG_LFM,
        SIG_PSK,
        SIG_FSK
    } dds_sig_type_e;

    function automatic logic [DDS_CNT_W-1:0] sat_inc(input logic [DDS_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push while full is accepted only
// when a pop frees the head slot in the same cycle; otherwise it is discarded.
module sync_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array has no reset; an empty FIFO never exposes it, so clearing it buys nothing.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/dds_output_reg.sv
// Consumer end of the phase-accumulator -> ROM -> output-register path: captures
// ROM samples per burst, packs LANES samples per DAC word and buffers words for the DAC.
module dds_output_reg
    import dds_pkg::*;
#(
    parameter int unsigned       DATA_W     = DDS_DATA_W,
    parameter int unsigned       LANES      = 4,
    parameter int unsigned       FIFO_DEPTH = 16,
    parameter int unsigned       ROM_LAT    = 1,
    parameter logic [DATA_W-1:0] PAD_VALUE  = '0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    SIGN_START_CALC,
    input  logic                    SIGN_STOP_CALC,
    input  logic [DATA_W-1:0]       ROM_DATA,
    output logic                    OUT_REG_READY,
    output logic [LANES*DATA_W-1:0] DAC_DATA,
    output logic                    DAC_VALID,
    input  logic                    DAC_READY,
    output logic                    OVERFLOW,
    output logic [DDS_CNT_W-1:0]    SAMPLE_COUNT,
    output logic                    BURST_DONE
);

    localparam int unsigned        LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned        DRAIN_W    = $clog2(ROM_LAT + 1);
    localparam logic [LANE_W-1:0]  LAST_LANE  = LANE_W'(LANES - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(ROM_LAT - 1);

    typedef logic [LANES-1:0][DATA_W-1:0] word_t;

    dds_state_e           state_q, state_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [ROM_LAT-1:0]   dly_q, dly_d;
    logic [LANE_W-1:0]    lane_idx_q, lane_idx_d;
    word_t                lanes_q, lanes_d;
    logic [DDS_CNT_W-1:0] count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 ready_q, ready_d;

    logic                 addr_vld;
    logic                 start_acc;
    logic                 cap;
    logic                 flush_push;
    logic                 push;
    word_t                push_word;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LANES*DATA_W-1:0] fifo_dout;

    assign addr_vld  = (state_q == CAPTURE);
    assign start_acc = (state_q == IDLE) && SIGN_START_CALC;
    assign cap       = dly_q[ROM_LAT-1];
    assign pop       = DAC_READY && !fifo_empty;

    // Address-valid delay line aligns each address with its ROM output.
    if (ROM_LAT == 1) begin : g_dly_one
        assign dly_d = addr_vld;
    end else begin : g_dly_multi
        assign dly_d = {dly_q[ROM_LAT-2:0], addr_vld};
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        flush_push  = 1'b0;
        case (state_q)
            IDLE: begin
                if (SIGN_START_CALC) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (SIGN_STOP_CALC) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == LAST_DRAIN) state_d = FLUSH;
                else                           drain_cnt_d = drain_cnt_q + 1'b1;
            end
            FLUSH: begin
                flush_push = (lane_idx_q != '0);
                state_d    = WAIT;
            end
            WAIT: begin
                if (fifo_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lanes_d    = lanes_q;
        lane_idx_d = lane_idx_q;
        count_d    = count_q;
        push       = 1'b0;
        push_word  = lanes_q;
        if (start_acc) count_d = '0;
        if (cap) begin
            lanes_d[lane_idx_q] = ROM_DATA;
            count_d             = sat_inc(count_q);
            if (lane_idx_q == LAST_LANE) begin
                push       = 1'b1;
                push_word  = lanes_d;
                lane_idx_d = '0;
            end else begin
                lane_idx_d = lane_idx_q + 1'b1;
            end
        end else if (flush_push) begin
            for (int i = 0; i < LANES; i++) begin
                if (LANE_W'(i) >= lane_idx_q) push_word[i] = PAD_VALUE;
            end
            push       = 1'b1;
            lane_idx_d = '0;
        end
    end

    // The accumulator is never stalled: a word that finds the FIFO full is dropped and flagged.
    assign overflow_d = overflow_q || (push && fifo_full && !pop);

    // IDLE is entered only once the FIFO has drained and nothing pushes while idle,
    // so the next-state term alone tracks "idle and empty" without a cycle of lag.
    assign ready_d = (state_d == IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            dly_q       <= '0;
            lane_idx_q  <= '0;
            lanes_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            dly_q       <= dly_d;
            lane_idx_q  <= lane_idx_d;
            lanes_q     <= lanes_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            ready_q     <= ready_d;
        end
    end

    sync_fifo #(
        .WIDTH (LANES*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_word),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign OUT_REG_READY = ready_q;
    assign DAC_DATA      = fifo_dout;
    assign DAC_VALID     = !fifo_empty;
    assign OVERFLOW      = overflow_q;
    assign SAMPLE_COUNT  = count_q;
    assign BURST_DONE    = (state_q == WAIT) && fifo_empty;

endmodule

// File: tb/tb_dds_output_reg.sv
// Bench for dds_output_reg: two instances (ROM_LAT 1 and 3) share control inputs,
// each fed by its own ROM latency model; DAC words are checked against a scoreboard.
module tb_dds_output_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        dac_ready = 1'b1;
    logic [11:0] rom_a = 12'hBAD;
    logic [11:0] rom_b = 12'hBAD;

    logic        ready_a, valid_a, ovf_a, done_a;
    logic        ready_b, valid_b, ovf_b, done_b;
    logic [47:0] data_a, data_b;
    logic [31:0] count_a, count_b;

    dds_output_reg #(
        .DATA_W(12), .LANES(4), .FIFO_DEPTH(16), .ROM_LAT(1), .PAD_VALUE(12'h000)
    ) dut_a (
        .CLK(clk), .RESET(rst), .SIGN_START_CALC(start), .SIGN_STOP_CALC(stop),
        .ROM_DATA(rom_a), .OUT_REG_READY(ready_a), .DAC_DATA(data_a), .DAC_VALID(valid_a),
        .DAC_READY(dac_ready), .OVERFLOW(ovf_a), .SAMPLE_COUNT(count_a), .BURST_DONE(done_a)
    );

    dds_output_reg #(
        .DATA_W(12), .LANES(4), .FIFO_DEPTH(16), .ROM_LAT(3), .PAD_VALUE(12'h000)
    ) dut_b (
        .CLK(clk), .RESET(rst), .SIGN_START_CALC(start), .SIGN_STOP_CALC(stop),
        .ROM_DATA(rom_b), .OUT_REG_READY(ready_b), .DAC_DATA(data_b), .DAC_VALID(valid_b),
        .DAC_READY(dac_ready), .OVERFLOW(ovf_b), .SAMPLE_COUNT(count_b), .BURST_DONE(done_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ROM model history: entry k holds the address issued k+1 cycles before the current one.
    logic        hv [8];
    logic [11:0] hd [8];
    logic        cur_vld = 1'b0;
    logic [11:0] cur_val = '0;

    initial begin
        for (int k = 0; k < 8; k++) begin
            hv[k] = 1'b0;
            hd[k] = '0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int k = 7; k > 0; k--) begin
            hv[k] = hv[k-1];
            hd[k] = hd[k-1];
        end
        hv[0]   = cur_vld;
        hd[0]   = cur_val;
        rom_a   = hv[0] ? hd[0] : 12'hBAD;
        rom_b   = hv[2] ? hd[2] : 12'hBAD;
        cur_vld = 1'b0;
    endtask

    // Scoreboard and monitor, sampling on the falling edge.
    logic [47:0] exp_a [$];
    logic [47:0] exp_b [$];
    logic [47:0] log_a [$];
    logic [47:0] log_b [$];
    int cyc_n = 0;
    int pops_a = 0, pops_b = 0;
    int done_cnt_a = 0, done_cnt_b = 0;
    int last_pop_a = 0, done_cyc_a = 0;

    always @(negedge clk) begin
        cyc_n++;
        if (valid_a && dac_ready) begin
            if (exp_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_extra_word: got %h, no word expected", data_a);
            end else begin
                check("a_word", {16'h0, data_a}, {16'h0, exp_a.pop_front()});
            end
            log_a.push_back(data_a);
            pops_a++;
            last_pop_a = cyc_n;
        end
        if (valid_b && dac_ready) begin
            if (exp_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_extra_word: got %h, no word expected", data_b);
            end else begin
                check("b_word", {16'h0, data_b}, {16'h0, exp_b.pop_front()});
            end
            log_b.push_back(data_b);
            pops_b++;
        end
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc_n;
        end
        if (done_b) done_cnt_b++;
    end

    // Expected packing: 4 lanes of 12 bits, lane 0 earliest, zero padding; keep caps retained words.
    task automatic push_expected(input int n, input logic [11:0] base, input int keep);
        logic [47:0] w;
        int lane;
        int words;
        w = '0;
        lane = 0;
        words = 0;
        for (int k = 0; k < n; k++) begin
            w[lane*12 +: 12] = 12'(base + 12'(k));
            lane++;
            if (lane == 4) begin
                if (words < keep) begin
                    exp_a.push_back(w);
                    exp_b.push_back(w);
                end
                words++;
                lane = 0;
                w = '0;
            end
        end
        if (lane != 0 && words < keep) begin
            exp_a.push_back(w);
            exp_b.push_back(w);
        end
    endtask

    task automatic run_burst(input int n, input logic [11:0] base, input int keep, input int restart_at);
        push_expected(n, base, keep);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            cur_vld = 1'b1;
            cur_val = 12'(base + 12'(k));
            stop    = (k == n - 1);
            start   = (k == restart_at);
            cyc();
            if (k == 2) check("ready_low_in_burst", {63'h0, ready_a}, 64'h0);
        end
        stop  = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(input int ta, input int tb);
        int i;
        i = 0;
        while ((done_cnt_a < ta || done_cnt_b < tb) && i < 2000) begin
            cyc();
            i++;
        end
        repeat (3) cyc();
        check("burst_done_count_a", 64'(done_cnt_a), 64'(ta));
        check("burst_done_count_b", 64'(done_cnt_b), 64'(tb));
    endtask

    typedef struct {
        int          n;
        logic [11:0] base;
        int          exp_count;
        int          exp_words;
        logic [47:0] exp_first;
        logic [47:0] exp_last;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pa0, pb0, da0, db0;
        logic [47:0] w;

        vecs[0] = '{8, 12'h001, 8, 2, 48'h004003002001, 48'h008007006005};
        vecs[1] = '{6, 12'h010, 6, 2, 48'h013012011010, 48'h000000015014};
        vecs[2] = '{1, 12'hABC, 1, 1, 48'h000000000ABC, 48'h000000000ABC};
        vecs[3] = '{5, 12'hFFE, 5, 2, 48'h001000FFFFFE, 48'h000000000002};

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_a", {63'h0, ready_a}, 64'h1);
        check("rst_valid_a", {63'h0, valid_a}, 64'h0);
        check("rst_data_a", {16'h0, data_a}, 64'h0);
        check("rst_ovf_a", {63'h0, ovf_a}, 64'h0);
        check("rst_count_a", {32'h0, count_a}, 64'h0);
        check("rst_done_a", {63'h0, done_a}, 64'h0);
        check("rst_ready_b", {63'h0, ready_b}, 64'h1);
        rst = 1'b0;
        cyc();
        cyc();

        // Table-driven bursts with DAC always ready
        for (int r = 0; r < 4; r++) begin
            pa0 = pops_a;
            pb0 = pops_b;
            da0 = done_cnt_a;
            db0 = done_cnt_b;
            check("ready_before_burst", {63'h0, ready_a}, 64'h1);
            run_burst(vecs[r].n, vecs[r].base, 16, -1);
            wait_done(da0 + 1, db0 + 1);
            check("count_a", {32'h0, count_a}, 64'(vecs[r].exp_count));
            check("count_b", {32'h0, count_b}, 64'(vecs[r].exp_count));
            check("words_a", 64'(pops_a - pa0), 64'(vecs[r].exp_words));
            check("words_b", 64'(pops_b - pb0), 64'(vecs[r].exp_words));
            w = (log_a.size() > pa0) ? log_a[pa0] : 48'hFFFF_FFFF_FFFF;
            check("first_word_a", {16'h0, w}, {16'h0, vecs[r].exp_first});
            w = (log_a.size() > 0) ? log_a[log_a.size() - 1] : 48'hFFFF_FFFF_FFFF;
            check("last_word_a", {16'h0, w}, {16'h0, vecs[r].exp_last});
            check("done_after_last_pop", 64'(done_cyc_a - last_pop_a), 64'h1);
            check("ready_after_a", {63'h0, ready_a}, 64'h1);
            check("ready_after_b", {63'h0, ready_b}, 64'h1);
            check("scoreboard_empty", 64'(exp_a.size() + exp_b.size()), 64'h0);
        end

        // DAC stalled for a 100-sample burst: FIFO holds 16 words, the rest are dropped
        dac_ready = 1'b0;
        pa0 = pops_a;
        pb0 = pops_b;
        da0 = done_cnt_a;
        db0 = done_cnt_b;
        run_burst(100, 12'h100, 16, -1);
        repeat (8) cyc();
        check("stall_ovf_a", {63'h0, ovf_a}, 64'h1);
        check("stall_ovf_b", {63'h0, ovf_b}, 64'h1);
        check("stall_count_a", {32'h0, count_a}, 64'd100);
        check("stall_count_b", {32'h0, count_b}, 64'd100);
        check("stall_valid_a", {63'h0, valid_a}, 64'h1);
        check("stall_head_a", {16'h0, data_a}, 64'h103102101100);
        check("stall_no_done", 64'(done_cnt_a - da0), 64'h0);
        dac_ready = 1'b1;
        wait_done(da0 + 1, db0 + 1);
        check("stall_popped_a", 64'(pops_a - pa0), 64'd16);
        check("stall_popped_b", 64'(pops_b - pb0), 64'd16);
        check("stall_scoreboard", 64'(exp_a.size() + exp_b.size()), 64'h0);

        // Second START during CAPTURE is ignored; OVERFLOW stays sticky across bursts
        pa0 = pops_a;
        da0 = done_cnt_a;
        db0 = done_cnt_b;
        run_burst(8, 12'h020, 16, 3);
        wait_done(da0 + 1, db0 + 1);
        check("restart_words", 64'(pops_a - pa0), 64'd2);
        check("restart_count", {32'h0, count_a}, 64'd8);
        check("ovf_sticky", {63'h0, ovf_a}, 64'h1);

        // Capture latency for ROM_LAT 1 and 3, with a padded last word
        pb0 = pops_b;
        da0 = done_cnt_a;
        db0 = done_cnt_b;
        push_expected(7, 12'h300, 16);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cur_vld = 1'b1;
            cur_val = 12'(12'h300 + 12'(k));
            stop    = (k == 6);
            cyc();
            if (k == 0) check("lat1_before_first", {32'h0, count_a}, 64'd0);
            if (k == 1) check("lat1_first", {32'h0, count_a}, 64'd1);
            if (k == 2) check("lat3_before_first", {32'h0, count_b}, 64'd0);
            if (k == 3) check("lat3_first", {32'h0, count_b}, 64'd1);
        end
        stop = 1'b0;
        wait_done(da0 + 1, db0 + 1);
        check("lat3_count", {32'h0, count_b}, 64'd7);
        check("lat3_words", 64'(pops_b - pb0), 64'd2);
        w = (log_b.size() > 0) ? log_b[log_b.size() - 1] : 48'hFFFF_FFFF_FFFF;
        check("lat3_last_word", {16'h0, w}, 64'h000306305304);

        // Reset asserted mid-CAPTURE with a word waiting in the FIFO
        dac_ready = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cur_vld = 1'b1;
            cur_val = 12'(12'h200 + 12'(k));
            cyc();
        end
        check("pre_rst_valid", {63'h0, valid_a}, 64'h1);
        check("pre_rst_ovf", {63'h0, ovf_a}, 64'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_ready_a", {63'h0, ready_a}, 64'h1);
        check("mid_rst_valid_a", {63'h0, valid_a}, 64'h0);
        check("mid_rst_data_a", {16'h0, data_a}, 64'h0);
        check("mid_rst_ovf_a", {63'h0, ovf_a}, 64'h0);
        check("mid_rst_count_a", {32'h0, count_a}, 64'h0);
        check("mid_rst_ready_b", {63'h0, ready_b}, 64'h1);
        check("mid_rst_count_b", {32'h0, count_b}, 64'h0);
        for (int k = 0; k < 8; k++) hv[k] = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        dac_ready = 1'b1;
        cyc();

        // Recovery burst after reset
        pa0 = pops_a;
        da0 = done_cnt_a;
        db0 = done_cnt_b;
        run_burst(4, 12'h400, 16, -1);
        wait_done(da0 + 1, db0 + 1);
        check("recover_count", {32'h0, count_a}, 64'd4);
        check("recover_words", 64'(pops_a - pa0), 64'd1);
        check("recover_ovf", {63'h0, ovf_a}, 64'h0);
        check("recover_scoreboard", 64'(exp_a.size() + exp_b.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
